tinycore_prog_loader: RTL and testbench

Program loader and instruction store for the tinycore accumulator CPU. It receives a length-prefixed, checksummed program over a byte valid/ready handshake and writes it into a 16-entry by 8-bit instruction memory. It then serves that memory to the core's fetch port and raises `core_run` to release the core. It is the writer side of the core's instruction-memory read interface and replaces the core's hard-wired program.

---
 rtl/tinycore_prog_loader.sv | 153 +++++++++++++++
 tb/tb_tinycore_prog_loader.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinycore_prog_loader.sv
// tinycore_prog_loader: receives a length-prefixed, checksummed program over a
// byte handshake, stores it in a 16x8 instruction memory, and serves that
// memory to the core fetch port once the program has been verified.
//
// Handshake: a byte moves on a rising edge where byte_valid & byte_ready.
// byte_ready is combinational and never depends on byte_valid; the host must
// hold byte_in/byte_valid stable until it sees byte_ready.
module tinycore_prog_loader #(
   parameter logic [7:0]  NOP_WORD = 8'hE0,
   parameter logic [23:0] TIMEOUT  = 24'd10_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       load_req,
   input  logic [7:0] byte_in,
   input  logic       byte_valid,
   output logic       byte_ready,
   input  logic [3:0] fetch_addr,
   output logic [7:0] fetch_data,
   output logic       core_run,
   output logic       error,
   output logic [4:0] loaded_len
);

   typedef enum logic [2:0] {IDLE, HDR, DATA, SUM, RUN, ERR} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  mem [16];
   logic [4:0]  idx;
   logic [4:0]  len;
   logic [7:0]  sum;
   logic [23:0] tcnt;

   logic in_load;
   logic accept;
   logic len_ok;
   logic last_data;
   logic sum_ok;
   logic tmo;

   assign in_load    = (state == HDR) || (state == DATA) || (state == SUM);
   // A pending load_req wins over any byte on the wire, so that byte stays put.
   assign byte_ready = ena & ~load_req & in_load;
   assign accept     = byte_valid & byte_ready;
   assign len_ok     = (byte_in >= 8'd1) && (byte_in <= 8'd16);
   assign last_data  = (idx == (len - 5'd1));
   assign sum_ok     = (byte_in == sum);
   // Counter equals TIMEOUT-1 on the TIMEOUT-th idle enabled cycle.
   assign tmo        = (tcnt == (TIMEOUT - 24'd1));

   // Next-state logic; load_req restarts from any state.
   always_comb begin
      state_nxt = state;
      if (ena) begin
         if (load_req) begin
            state_nxt = HDR;
         end else begin
            case (state)
               HDR: begin
                  if (accept)   state_nxt = len_ok ? DATA : ERR;
                  else if (tmo) state_nxt = ERR;
               end
               DATA: begin
                  if (accept) begin
                     if (last_data) state_nxt = SUM;
                  end else if (tmo) begin
                     state_nxt = ERR;
                  end
               end
               SUM: begin
                  if (accept)   state_nxt = sum_ok ? RUN : ERR;
                  else if (tmo) state_nxt = ERR;
               end
               default: state_nxt = state;
            endcase
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Load bookkeeping: index, length, checksum, timeout and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx        <= 5'd0;
         len        <= 5'd0;
         sum        <= 8'd0;
         tcnt       <= 24'd0;
         core_run   <= 1'b0;
         error      <= 1'b0;
         loaded_len <= 5'd0;
      end else if (ena) begin
         if (load_req) begin
            idx      <= 5'd0;
            sum      <= 8'd0;
            tcnt     <= 24'd0;
            core_run <= 1'b0;
            error    <= 1'b0;
         end else begin
            if (accept)       tcnt <= 24'd0;
            else if (in_load) tcnt <= tcnt + 24'd1;
            case (state)
               HDR: begin
                  if (accept && len_ok) begin
                     len <= byte_in[4:0];
                     sum <= byte_in;
                     idx <= 5'd0;
                  end
               end
               DATA: begin
                  if (accept) begin
                     sum <= sum + byte_in;
                     idx <= idx + 5'd1;
                  end
               end
               SUM: begin
                  if (accept && sum_ok) begin
                     core_run   <= 1'b1;
                     loaded_len <= len;
                  end
               end
               default: ;
            endcase
            if (in_load && (state_nxt == ERR)) error <= 1'b1;
         end
      end
   end

   // Instruction memory: NOP fill on reset and load start, byte writes in DATA.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) mem[i] <= NOP_WORD;
      end else if (ena && load_req) begin
         for (int i = 0; i < 16; i++) mem[i] <= NOP_WORD;
      end else if (accept && (state == DATA)) begin
         mem[idx[3:0]] <= byte_in;
      end
   end

   // Fetch port: registered read, NOP while the core is held; a same-cycle
   // write to the addressed word returns the old contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fetch_data <= NOP_WORD;
      else        fetch_data <= core_run ? mem[fetch_addr] : NOP_WORD;
   end

endmodule

// File: tb/tb_tinycore_prog_loader.sv
// Testbench for tinycore_prog_loader: directed frames from the test plan plus
// randomized frames, with a fetch scoreboard fed by a frame-level model.
module tb_tinycore_prog_loader;

   localparam logic [7:0] NOP = 8'hE0;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic       load_req = 1'b0;
   logic [7:0] byte_in = 8'd0;
   logic       byte_valid = 1'b0;
   logic       byte_ready;
   logic [3:0] fetch_addr = 4'd0;
   logic [7:0] fetch_data;
   logic       core_run;
   logic       error;
   logic [4:0] loaded_len;

   int   n_cmp = 0;
   int   n_err = 0;
   logic ena_toggle = 1'b0;
   logic rd_req = 1'b0;
   logic issued = 1'b0;

   logic [7:0] exp_q[$];

   // Frame-level reference model of what the core can observe.
   logic [7:0] ref_mem [16];
   logic       ref_run = 1'b0;
   logic       ref_err = 1'b0;
   logic [4:0] ref_len = 5'd0;

   tinycore_prog_loader #(.NOP_WORD(NOP), .TIMEOUT(24'd8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .load_req   (load_req),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .fetch_addr (fetch_addr),
      .fetch_data (fetch_data),
      .core_run   (core_run),
      .error      (error),
      .loaded_len (loaded_len)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish before 2ms");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: a read issued before an edge is compared on the following negedge.
   always @(posedge clk) issued <= rd_req;

   always @(negedge clk) begin
      if (issued) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL fetch_unexpected: got %0h expected none", fetch_data);
         end else begin
            chk("fetch_data", {24'd0, fetch_data}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   // Driver tasks: each starts and ends just after a falling edge.
   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic rd(input int a);
      fetch_addr = a[3:0];
      rd_req     = 1'b1;
      exp_q.push_back(ref_run ? ref_mem[a] : NOP);
      cycle();
      rd_req = 1'b0;
   endtask

   task automatic read_all();
      for (int a = 0; a < 16; a++) rd(a);
   endtask

   task automatic model_clear();
      ref_run = 1'b0;
      ref_err = 1'b0;
      for (int i = 0; i < 16; i++) ref_mem[i] = NOP;
   endtask

   task automatic load_pulse();
      load_req = 1'b1;
      cycle();
      load_req = 1'b0;
      model_clear();
   endtask

   task automatic send_byte(input logic [7:0] b);
      int   budget;
      logic acc;
      budget     = 0;
      acc        = 1'b0;
      byte_in    = b;
      byte_valid = 1'b1;
      while (!acc && budget < 64) begin
         if (ena_toggle) ena = ~ena;
         #1;
         acc = byte_ready;
         cycle();
         budget++;
      end
      if (!acc) begin
         n_cmp++;
         n_err++;
         $display("FAIL accept_timeout: got no byte_ready expected accept of %0h", b);
      end
      byte_valid = 1'b0;
   endtask

   task automatic gap(input int gmin, input int gmax);
      int g;
      g = $urandom_range(gmax, gmin);
      byte_valid = 1'b0;
      repeat (g) cycle();
   endtask

   task automatic check_status(input string tag);
      chk({tag, "_core_run"}, {31'd0, core_run}, {31'd0, ref_run});
      chk({tag, "_error"}, {31'd0, error}, {31'd0, ref_err});
      chk({tag, "_loaded_len"}, {27'd0, loaded_len}, {27'd0, ref_len});
   endtask

   // One complete frame; sum_delta != 0 corrupts the checksum byte.
   task automatic run_frame(input int len, input logic [7:0] data [16],
                            input logic [7:0] sum_delta, input int gmin, input int gmax);
      logic [7:0] s;
      load_pulse();
      send_byte(len[7:0]);
      if (len < 1 || len > 16) begin
         ref_err = 1'b1;
         check_status("hdr");
         #1;
         chk("hdr_byte_ready", {31'd0, byte_ready}, 32'd0);
         return;
      end
      s = len[7:0];
      for (int i = 0; i < len; i++) begin
         gap(gmin, gmax);
         send_byte(data[i]);
         s = s + data[i];
      end
      gap(gmin, gmax);
      send_byte(s + sum_delta);
      if (sum_delta == 8'd0) begin
         ref_run = 1'b1;
         ref_len = len[4:0];
         for (int i = 0; i < len; i++) ref_mem[i] = data[i];
      end else begin
         ref_err = 1'b1;
      end
      check_status("frame");
   endtask

   // Stimulus and final report.
   initial begin
      logic [7:0] d [16];
      int         len;
      logic [7:0] delta;

      model_clear();
      for (int i = 0; i < 16; i++) d[i] = 8'd0;

      // Reset values.
      repeat (2) @(negedge clk);
      #1;
      chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
      chk("rst_fetch", {24'd0, fetch_data}, {24'd0, NOP});
      check_status("rst");
      @(negedge clk);
      rst_n = 1'b1;
      cycle();

      // Directed frame 02 41 22 65.
      load_pulse();
      send_byte(8'h02);
      send_byte(8'h41);
      send_byte(8'h22);
      chk("pre_sum_core_run", {31'd0, core_run}, 32'd0);
      send_byte(8'h65);
      ref_run = 1'b1;
      ref_len = 5'd2;
      ref_mem[0] = 8'h41;
      ref_mem[1] = 8'h22;
      check_status("f1");
      chk("f1_fetch_first_edge", {24'd0, fetch_data}, {24'd0, NOP});
      cycle();
      chk("f1_fetch_next_edge", {24'd0, fetch_data}, 32'h41);
      rd(0);
      rd(1);
      rd(5);

      // Same frame with checksum 66.
      d[0] = 8'h41;
      d[1] = 8'h22;
      run_frame(2, d, 8'd1, 0, 0);
      read_all();
      load_pulse();
      #1;
      chk("clr_error", {31'd0, error}, 32'd0);
      chk("clr_byte_ready", {31'd0, byte_ready}, 32'd1);

      // Bad headers 00 and 11.
      run_frame(0, d, 8'd0, 0, 0);
      run_frame(17, d, 8'd0, 0, 0);
      rd(0);

      // Timeout: error on the 8th idle enabled cycle after byte 20.
      load_pulse();
      send_byte(8'h03);
      send_byte(8'h20);
      repeat (7) cycle();
      chk("tmo_before", {31'd0, error}, 32'd0);
      cycle();
      ref_err = 1'b1;
      chk("tmo_at", {31'd0, error}, 32'd1);

      // Gaps of exactly 7 idle cycles stay clear of the timeout.
      for (int i = 0; i < 16; i++) d[i] = 8'($urandom_range(255, 0));
      run_frame(3, d, 8'd0, 7, 7);
      read_all();

      // Full 16-word load, byte_valid held, ena toggled.
      for (int i = 0; i < 16; i++) d[i] = 8'($urandom_range(255, 0));
      ena_toggle = 1'b1;
      run_frame(16, d, 8'd0, 0, 0);
      ena_toggle = 1'b0;
      ena = 1'b1;
      read_all();

      // load_req together with byte_valid during RUN.
      load_req   = 1'b1;
      byte_valid = 1'b1;
      byte_in    = 8'h01;
      #1;
      chk("lr_byte_ready", {31'd0, byte_ready}, 32'd0);
      cycle();
      load_req = 1'b0;
      model_clear();
      #1;
      chk("lr_core_run", {31'd0, core_run}, 32'd0);
      chk("lr_hdr_ready", {31'd0, byte_ready}, 32'd1);
      send_byte(8'h01);
      send_byte(8'hAA);
      send_byte(8'hAB);
      ref_run = 1'b1;
      ref_len = 5'd1;
      ref_mem[0] = 8'hAA;
      check_status("lr");
      read_all();

      // Randomized frames.
      for (int f = 0; f < 10; f++) begin
         len = $urandom_range(16, 1);
         if ($urandom_range(7, 0) == 0) len = $urandom_range(255, 17);
         delta = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'd0;
         for (int i = 0; i < 16; i++) d[i] = 8'($urandom_range(255, 0));
         run_frame(len, d, delta, 0, 7);
         for (int k = 0; k < 5; k++) rd($urandom_range(15, 0));
      end

      // Reset in the middle of a load.
      load_pulse();
      send_byte(8'h04);
      send_byte(8'h11);
      send_byte(8'h22);
      rst_n = 1'b0;
      model_clear();
      ref_len = 5'd0;
      #1;
      check_status("mid_rst");
      chk("mid_rst_fetch", {24'd0, fetch_data}, {24'd0, NOP});
      cycle();
      rst_n = 1'b1;
      #1;
      chk("mid_rst_idle_ready", {31'd0, byte_ready}, 32'd0);
      cycle();
      rd(0);

      repeat (3) cycle();
      chk("exp_q_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
